// File: rtl/hdmi_line_pkg.sv
// Shared constants and state encoding for the HDMI 720p line buffer scanout path.
package hdmi_line_pkg;
  localparam int LINE_PIXELS_720P = 1280;
  localparam int BANK_OFFSET      = 2048;
  localparam int ADDR_WIDTH       = 12;
  localparam int FIFO_DEPTH       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } line_state_t;
endpackage

// File: rtl/line_buffer_reader_prefetch_fifo.sv
// 4x8 prefetch FIFO; head is visible combinationally, push and pop may share a cycle.
module prefetch_fifo
  import hdmi_line_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic [2:0] count
);
  logic [7:0] mem [FIFO_DEPTH];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic       do_push;
  logic       do_pop;

  always_comb begin
    do_pop  = pop && (count != 3'd0);
    do_push = push && ((count != 3'(FIFO_DEPTH)) || do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 2'd1;
      end
      if (do_pop) rptr <= rptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rptr];
endmodule

// File: rtl/line_buffer_reader.sv
// Streams one line from a line-RAM bank to the pixel formatter, hiding the
// one-cycle RAM read latency behind a small prefetch FIFO.
module line_buffer_reader #(
  parameter int LINE_PIXELS = hdmi_line_pkg::LINE_PIXELS_720P,
  parameter int BANK_OFFSET = hdmi_line_pkg::BANK_OFFSET,
  parameter int ADDR_WIDTH  = hdmi_line_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  startLine,
  input  logic                  bankSelect,
  output logic                  busy,
  output logic                  lineDone,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [7:0]            ramData,
  output logic [7:0]            pixelData,
  output logic                  pixelValid,
  input  logic                  pixelReady,
  output logic                  pixelLast,
  output logic [1:0]            debugState
);
  import hdmi_line_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LINE_LEN = ADDR_WIDTH'(LINE_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LINE_PIXELS - 1);

  line_state_t           state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] issue_count;
  logic [ADDR_WIDTH-1:0] out_count;
  logic [ADDR_WIDTH-1:0] bank_base;
  // tag[0]: address on ramAddress this cycle; tag[1]: its data on ramData now
  logic [1:0]            tag;
  logic [2:0]            fifo_count;
  logic [2:0]            in_flight;
  logic [2:0]            occupancy;
  logic                  accept;
  logic                  issue;
  logic                  handshake;

  always_comb begin
    bank_base = bankSelect ? ADDR_WIDTH'(BANK_OFFSET) : '0;
    in_flight = {2'b00, tag[0]} + {2'b00, tag[1]};
    occupancy = fifo_count + in_flight;
    accept    = (state == ST_IDLE) && startLine;
    issue     = (state == ST_STREAM) && (issue_count < LINE_LEN) &&
                (occupancy < 3'(FIFO_DEPTH));
    handshake = pixelValid && pixelReady;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      base        <= '0;
      issue_count <= '0;
      out_count   <= '0;
      ramAddress  <= '0;
      tag         <= 2'b00;
    end else begin
      tag <= {tag[0], accept || issue};
      case (state)
        ST_IDLE: begin
          if (startLine) begin
            // the first read goes out on the accepting edge itself
            base        <= bank_base;
            ramAddress  <= bank_base;
            issue_count <= ADDR_WIDTH'(1);
            out_count   <= '0;
            state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (issue) begin
            ramAddress  <= base + issue_count;
            issue_count <= issue_count + ADDR_WIDTH'(1);
          end
          if (handshake) begin
            out_count <= out_count + ADDR_WIDTH'(1);
            if (pixelLast) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  prefetch_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tag[1]),
    .push_data (ramData),
    .pop       (handshake),
    .head_data (pixelData),
    .count     (fifo_count)
  );

  assign pixelValid = (fifo_count != 3'd0);
  assign pixelLast  = pixelValid && (out_count == LAST_IDX);
  assign busy       = (state != ST_IDLE);
  assign lineDone   = (state == ST_DONE);
  assign debugState = state;
endmodule

// File: tb/tb_line_buffer_reader.sv
// Bench for line_buffer_reader: full-length lines on both banks, random
// backpressure, ignored start requests, mid-line reset and a one-pixel line.
module tb_line_buffer_reader;
  localparam int LP = 1280;

  typedef struct {
    logic        bank;
    int unsigned ready_pct;
    logic        poke;
    logic [11:0] exp_base;
    int          exp_fv;
    int          exp_lc;
  } line_vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        startLine, bankSelect, busy, lineDone;
  logic [11:0] ramAddress;
  logic [7:0]  ramData, pixelData;
  logic        pixelValid, pixelReady, pixelLast;
  logic [1:0]  debugState;

  logic        startLine1, bankSelect1, busy1, lineDone1;
  logic [11:0] ramAddress1;
  logic [7:0]  ramData1, pixelData1;
  logic        pixelValid1, pixelReady1, pixelLast1;
  logic [1:0]  debugState1;

  logic [7:0]  mem [4096];
  logic [7:0]  exp_q[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int unsigned ready_pct = 100;
  logic        mon_en = 1'b0;
  logic [11:0] exp_base = 12'd0;
  int          popped = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  line_vec_t   vecs [5];

  always #5 clock = ~clock;

  always @(posedge clock) ramData  <= mem[ramAddress];
  always @(posedge clock) ramData1 <= mem[ramAddress1];

  line_buffer_reader dut (
    .clock(clock), .reset(reset), .startLine(startLine), .bankSelect(bankSelect),
    .busy(busy), .lineDone(lineDone), .ramAddress(ramAddress), .ramData(ramData),
    .pixelData(pixelData), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .pixelLast(pixelLast), .debugState(debugState)
  );

  line_buffer_reader #(.LINE_PIXELS(1)) dut1 (
    .clock(clock), .reset(reset), .startLine(startLine1), .bankSelect(bankSelect1),
    .busy(busy1), .lineDone(lineDone1), .ramAddress(ramAddress1), .ramData(ramData1),
    .pixelData(pixelData1), .pixelValid(pixelValid1), .pixelReady(pixelReady1),
    .pixelLast(pixelLast1), .debugState(debugState1)
  );

  initial begin
    pixelReady = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      pixelReady = ($urandom_range(99) < ready_pct);
    end
  end

  function automatic logic [7:0] exp_pix(input logic bank, input int i);
    logic [7:0] v;
    v = i[7:0];
    return bank ? ~v : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one negedge; scoreboard and handshake properties of the main instance
  task automatic tick();
    int issued;
    logic [7:0] e;
    @(negedge clock);
    cyc++;
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", pixelValid, 1);
        check("stall_data", pixelData, prev_data);
      end
      if (busy) begin
        issued = int'(ramAddress) - int'(exp_base) + 1;
        check("addr_range", (ramAddress >= exp_base) && (int'(ramAddress) <= int'(exp_base) + LP - 1), 1);
        check("occupancy_le_4", (issued - popped) <= 4, 1);
      end
      if (pixelValid && pixelReady) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_pixel: actual=%0h required=no pixel (cycle %0d)", pixelData, cyc);
        end else begin
          e = exp_q.pop_front();
          if (pixelData !== e) begin
            bad++;
            $display("FAIL pixel[%0d]: actual=%0h required=%0h", popped, pixelData, e);
          end
          check("pixel_last", pixelLast, popped == LP - 1);
        end
        popped++;
      end
      prev_stall = pixelValid && !pixelReady;
      prev_data  = pixelData;
    end
  endtask

  // call at a negedge with the DUT idle; returns at cycle T+1 after acceptance
  task automatic start_line(input logic bank, input logic [11:0] b);
    check("idle_before_start", busy, 0);
    exp_q.delete();
    exp_base   = b;
    popped     = 0;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
    for (int i = 0; i < LP; i++) exp_q.push_back(exp_pix(bank, i));
    bankSelect = bank;
    startLine  = 1'b1;
    tick();
    startLine  = 1'b0;
    bankSelect = ~bank;
    check("first_addr", ramAddress, b);
    check("busy_after_accept", busy, 1);
    check("state_stream", debugState, 2'd1);
  endtask

  task automatic run_line(input line_vec_t v);
    int k, fv, lc, dc;
    fv = 0; lc = 0; dc = 0;
    ready_pct = v.ready_pct;
    start_line(v.bank, v.exp_base);
    k = 1;
    while (dc == 0 && k < 20000) begin
      if (pixelValid && fv == 0) fv = k;
      if (pixelValid && pixelReady && pixelLast) lc = k;
      if (lineDone) dc = k;
      else begin
        if (v.poke && k == 100) startLine = 1'b1;
        if (v.poke && k == 101) startLine = 1'b0;
        tick();
        k++;
      end
    end
    check("line_done_seen", dc != 0, 1);
    check("first_valid_cycle", fv, v.exp_fv);
    if (v.exp_lc != 0) check("last_pixel_cycle", lc, v.exp_lc);
    check("done_after_last", dc, lc + 1);
    check("pixel_count", popped, LP);
    check("queue_drained", exp_q.size(), 0);
    check("state_done", debugState, 2'd2);
    if (v.poke) startLine = 1'b1;
    tick();
    startLine = 1'b0;
    check("done_one_cycle", lineDone, 0);
    check("busy_after_done", busy, 0);
    tick();
    check("still_idle", busy, 0);
  endtask

  initial begin
    startLine = 1'b0; bankSelect = 1'b0;
    startLine1 = 1'b0; bankSelect1 = 1'b0; pixelReady1 = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      mem[i]        = exp_pix(1'b0, i);
      mem[2048 + i] = exp_pix(1'b1, i);
    end
    vecs[0] = '{1'b0, 100, 1'b0, 12'd0,    3, 2 + LP};
    vecs[1] = '{1'b1, 100, 1'b1, 12'd2048, 3, 2 + LP};
    vecs[2] = '{1'b0, 50,  1'b1, 12'd0,    3, 0};
    vecs[3] = '{1'b1, 50,  1'b0, 12'd2048, 3, 0};
    vecs[4] = '{1'b0, 100, 1'b1, 12'd0,    3, 2 + LP};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_line_done", lineDone, 0);
    check("rst_valid", pixelValid, 0);
    check("rst_last", pixelLast, 0);
    check("rst_data", pixelData, 0);
    check("rst_addr", ramAddress, 0);
    check("rst_state", debugState, 0);
    check("rst1_busy", busy1, 0);
    check("rst1_valid", pixelValid1, 0);

    for (int i = 0; i < 5; i++) run_line(vecs[i]);

    // reset in the middle of a line
    ready_pct = 100;
    start_line(1'b0, 12'd0);
    for (int g = 0; g < 5000 && popped < 600; g++) tick();
    reset  = 1'b1;
    mon_en = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("midrst_valid", pixelValid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_line_done", lineDone, 0);
    check("midrst_addr", ramAddress, 0);
    check("midrst_data", pixelData, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("postrst_quiet", {lineDone, pixelValid, busy}, 3'b000);
    end
    run_line(vecs[3]);

    // single-pixel line on the LINE_PIXELS=1 instance
    mon_en = 1'b0;
    bankSelect1 = 1'b1;
    startLine1  = 1'b1;
    tick();
    startLine1  = 1'b0;
    bankSelect1 = 1'b0;
    check("lp1_addr", ramAddress1, 12'd2048);
    check("lp1_busy", busy1, 1);
    check("lp1_valid_t1", pixelValid1, 0);
    tick();
    check("lp1_valid_t2", pixelValid1, 0);
    tick();
    check("lp1_valid_t3", pixelValid1, 1);
    check("lp1_last", pixelLast1, 1);
    check("lp1_data", pixelData1, exp_pix(1'b1, 0));
    check("lp1_done_early", lineDone1, 0);
    tick();
    check("lp1_done", lineDone1, 1);
    check("lp1_valid_after", pixelValid1, 0);
    tick();
    check("lp1_idle", busy1, 0);
    check("lp1_done_pulse", lineDone1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
